// File: rtl/kuznechik_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kuznechik_pkg: shared types for the Kuznechik byte streamer        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package kuznechik_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef logic [127:0] block_t;

  typedef enum logic [2:0] {
    FILL       = 3'd0,
    WAIT_IDLE  = 3'd1,
    REQ        = 3'd2,
    WAIT_VALID = 3'd3,
    ACK        = 3'd4,
    DRAIN      = 3'd5
  } streamer_state_t;

endpackage
`default_nettype wire

// File: rtl/kuznechik_byte_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | kuznechik_byte_streamer: packs bytes into cipher blocks and        |
// | streams the ciphertext back out MSB-first. Revision: 1.0           |
// +--------------------------------------------------------------------+
module kuznechik_byte_streamer
  import kuznechik_pkg::*;
#(
  parameter logic [7:0]  PAD_BYTE       = 8'h00,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [7:0]   s_data_i,
  input  logic         s_valid_i,
  input  logic         s_last_i,
  output logic         s_ready_o,
  output logic [127:0] cph_data_o,
  output logic         cph_request_o,
  output logic         cph_ack_o,
  input  logic [127:0] cph_data_i,
  input  logic         cph_valid_i,
  input  logic         cph_busy_i,
  output logic [7:0]   m_data_o,
  output logic         m_valid_o,
  output logic         m_last_o,
  input  logic         m_ready_i,
  output logic         err_o
);

  localparam logic [3:0]  LAST_IDX = 4'(BLOCK_BYTES - 1);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 32'd1);

  streamer_state_t state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  block_t          in_blk_q, in_blk_d;
  block_t          out_sr_q, out_sr_d;
  logic [31:0]     tmo_q, tmo_d;
  logic            last_flag_q, last_flag_d;
  logic            s_ready_q, s_ready_d;
  logic            req_q, req_d;
  logic            ack_q, ack_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            err_q, err_d;

  logic s_fire;
  logic m_fire;

  assign s_fire = s_valid_i && s_ready_q;
  assign m_fire = m_valid_q && m_ready_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_blk_d    = in_blk_q;
    out_sr_d    = out_sr_q;
    tmo_d       = tmo_q;
    last_flag_d = last_flag_q;
    s_ready_d   = s_ready_q;
    req_d       = 1'b0;
    ack_d       = 1'b0;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    err_d       = err_q;

    case (state_q)
      FILL: begin
        if (s_fire) begin
          // Write the byte at its slot; a closing s_last_i pads every later slot.
          for (int i = 0; i < BLOCK_BYTES; i++) begin
            if (4'(i) == cnt_q) begin
              in_blk_d[8*(BLOCK_BYTES-1-i) +: 8] = s_data_i;
            end else if (s_last_i && (4'(i) > cnt_q)) begin
              in_blk_d[8*(BLOCK_BYTES-1-i) +: 8] = PAD_BYTE;
            end
          end
          if (s_last_i || (cnt_q == LAST_IDX)) begin
            state_d     = WAIT_IDLE;
            cnt_d       = 4'd0;
            last_flag_d = s_last_i;
            s_ready_d   = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end

      WAIT_IDLE: begin
        if (!cph_busy_i) begin
          state_d = REQ;
          req_d   = 1'b1;
        end
      end

      REQ: begin
        state_d = WAIT_VALID;
        tmo_d   = 32'd0;
      end

      WAIT_VALID: begin
        if (cph_valid_i) begin
          out_sr_d = cph_data_i;
          state_d  = ACK;
          ack_d    = 1'b1;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          // Abandon the block; the flag stays up but traffic continues.
          err_d     = 1'b1;
          state_d   = FILL;
          s_ready_d = 1'b1;
          cnt_d     = 4'd0;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end

      ACK: begin
        state_d   = DRAIN;
        m_valid_d = 1'b1;
        m_last_d  = 1'b0;
      end

      DRAIN: begin
        if (m_fire) begin
          out_sr_d = {out_sr_q[119:0], 8'h00};
          if (cnt_q == LAST_IDX) begin
            state_d   = FILL;
            cnt_d     = 4'd0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            s_ready_d = 1'b1;
          end else begin
            cnt_d    = cnt_q + 4'd1;
            m_last_d = last_flag_q && (cnt_q == (LAST_IDX - 4'd1));
          end
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= FILL;
      cnt_q       <= 4'd0;
      in_blk_q    <= '0;
      out_sr_q    <= '0;
      tmo_q       <= 32'd0;
      last_flag_q <= 1'b0;
      s_ready_q   <= 1'b1;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_blk_q    <= in_blk_d;
      out_sr_q    <= out_sr_d;
      tmo_q       <= tmo_d;
      last_flag_q <= last_flag_d;
      s_ready_q   <= s_ready_d;
      req_q       <= req_d;
      ack_q       <= ack_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      err_q       <= err_d;
    end
  end

  assign s_ready_o     = s_ready_q;
  assign cph_data_o    = in_blk_q;
  assign cph_request_o = req_q;
  assign cph_ack_o     = ack_q;
  assign m_data_o      = out_sr_q[127:120];
  assign m_valid_o     = m_valid_q;
  assign m_last_o      = m_last_q;
  assign err_o         = err_q;

endmodule
`default_nettype wire

// File: tb/tb_kuznechik_byte_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_kuznechik_byte_streamer: directed bench with an inline cipher   |
// | stand-in (ciphertext = block ^ KEY). Revision: 1.0                 |
// +--------------------------------------------------------------------+
module tb_kuznechik_byte_streamer;
  import kuznechik_pkg::*;

  localparam block_t KEY      = 128'h00112233445566778899aabbccddeeff;
  localparam int     STUB_LAT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [127:0] cph_data_o;
  logic         cph_request;
  logic         cph_ack;
  block_t       stub_data;
  logic         stub_valid;
  logic         stub_busy;
  logic         cph_busy;
  logic [7:0]   m_data;
  logic         m_valid;
  logic         m_last;
  logic         m_ready = 1'b0;
  logic         err;

  logic busy_force  = 1'b0;
  logic never_valid = 1'b0;
  int   stub_cnt;
  int   compared   = 0;
  int   mismatched = 0;
  int   req_pulses = 0;
  int   ack_pulses = 0;

  always #5 clk = ~clk;

  assign cph_busy = stub_busy | busy_force;

  kuznechik_byte_streamer #(
    .PAD_BYTE      (8'h00),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .s_data_i     (s_data),
    .s_valid_i    (s_valid),
    .s_last_i     (s_last),
    .s_ready_o    (s_ready),
    .cph_data_o   (cph_data_o),
    .cph_request_o(cph_request),
    .cph_ack_o    (cph_ack),
    .cph_data_i   (stub_data),
    .cph_valid_i  (stub_valid),
    .cph_busy_i   (cph_busy),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last),
    .m_ready_i    (m_ready),
    .err_o        (err)
  );

  // Cipher stand-in: busy for STUB_LAT cycles, then holds valid until ack.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy  <= 1'b0;
      stub_valid <= 1'b0;
      stub_data  <= '0;
      stub_cnt   <= 0;
    end else if (!stub_busy && cph_request) begin
      if (!never_valid) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 0;
        stub_data <= cph_data_o ^ KEY;
      end
    end else if (stub_busy && !stub_valid) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == STUB_LAT - 1) stub_valid <= 1'b1;
    end else if (stub_valid && cph_ack) begin
      stub_valid <= 1'b0;
      stub_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cph_request) req_pulses++;
    if (cph_ack) ack_pulses++;
  end

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_byte(input string tag, input int idx, input logic [7:0] obs,
                            input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s[%0d]: observed %h expected %h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_blk(input string tag, input block_t obs, input block_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    int t = 0;
    @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    s_last  = last;
    while (!s_ready) begin
      t++;
      if (t > 500) begin
        check_bit("s_ready_wait", s_ready, 1'b1);
        s_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  // Sends the first n bytes of v (MSB-first); s_last_i on byte n when last=1.
  task automatic send_block(input block_t v, input int n, input logic last);
    for (int i = 0; i < n; i++) begin
      send_byte(v[8*(15-i) +: 8], last && (i == n - 1));
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_bit("s_ready_drop", s_ready, 1'b0);
  endtask

  task automatic wait_req();
    int t = 0;
    while (!cph_request) begin
      t++;
      if (t > 500) begin
        check_bit("req_wait", cph_request, 1'b1);
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic recv_byte(input int idx, input logic [7:0] exp, input logic exp_last,
                           input bit rnd);
    int t = 0;
    forever begin
      @(negedge clk);
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_valid && m_ready) break;
      t++;
      if (t > 500) begin
        check_bit("m_valid_wait", m_valid, 1'b1);
        return;
      end
    end
    check_byte("m_data", idx, m_data, exp);
    check_bit("m_last", m_last, exp_last);
    check_bit("s_ready_in_drain", s_ready, 1'b0);
  endtask

  task automatic recv_block(input block_t exp_out, input logic exp_last, input bit rnd,
                            input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      recv_byte(i, exp_out[8*(15-i) +: 8], exp_last && (i == 15), rnd);
    end
    if (nbytes == 16) begin
      @(negedge clk);
      m_ready = 1'b0;
      check_bit("s_ready_after_drain", s_ready, 1'b1);
      check_bit("m_valid_after_drain", m_valid, 1'b0);
    end
  endtask

  initial begin
    block_t v1, v2, v3, v5;
    int     r0, a0;
    logic   no_req;

    v1 = 128'h3ee5c99f9a41c389ac17b4fe99c72ae4;
    v2 = 128'h01020300_00000000_00000000_00000000;
    v3 = 128'h101112131415161718191a1b1c1d1e1f;
    v5 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;

    // Reset state
    repeat (2) @(negedge clk);
    check_bit("rst_s_ready", s_ready, 1'b1);
    check_bit("rst_m_valid", m_valid, 1'b0);
    check_bit("rst_request", cph_request, 1'b0);
    check_bit("rst_ack", cph_ack, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_bit("rst_m_last", m_last, 1'b0);
    check_blk("rst_cph_data", cph_data_o, '0);
    check_byte("rst_m_data", 0, m_data, 8'h00);
    rst = 1'b0;

    // Full block with s_last_i on the 16th byte
    r0 = req_pulses;
    a0 = ack_pulses;
    send_block(v1, 16, 1'b1);
    wait_req();
    check_blk("full_cph_data", cph_data_o, v1);
    recv_block(v1 ^ KEY, 1'b1, 1'b0, 16);
    check_int("full_req_pulses", req_pulses - r0, 1);
    check_int("full_ack_pulses", ack_pulses - a0, 1);

    // Partial block closed on byte 3, padded with zeros
    send_block(v2, 3, 1'b1);
    wait_req();
    check_blk("partial_cph_data", cph_data_o, v2);
    recv_block(v2 ^ KEY, 1'b1, 1'b0, 16);

    // Busy hold for 20 cycles, then random output backpressure, no s_last_i
    busy_force = 1'b1;
    send_block(v3, 16, 1'b0);
    no_req = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (cph_request) no_req = 1'b0;
    end
    check_bit("busy_hold_no_req", no_req, 1'b1);
    busy_force = 1'b0;
    @(negedge clk);
    check_bit("req_after_busy", cph_request, 1'b1);
    check_blk("busy_cph_data", cph_data_o, v3);
    recv_block(v3 ^ KEY, 1'b0, 1'b1, 16);

    // Timeout: cipher never returns valid
    never_valid = 1'b1;
    a0 = ack_pulses;
    send_block(v5, 16, 1'b1);
    wait_req();
    repeat (8) @(negedge clk);
    check_bit("err_before_timeout", err, 1'b0);
    @(negedge clk);
    check_bit("err_at_timeout", err, 1'b1);
    check_bit("s_ready_at_timeout", s_ready, 1'b1);
    check_bit("m_valid_at_timeout", m_valid, 1'b0);
    check_int("timeout_no_ack", ack_pulses - a0, 0);
    never_valid = 1'b0;

    // Good block after a timeout; err stays set
    send_block(v5, 16, 1'b1);
    wait_req();
    check_blk("post_tmo_cph_data", cph_data_o, v5);
    recv_block(v5 ^ KEY, 1'b1, 1'b0, 16);
    check_bit("err_sticky", err, 1'b1);

    // Reset in the middle of draining
    send_block(v1, 16, 1'b1);
    wait_req();
    recv_block(v1 ^ KEY, 1'b0, 1'b0, 5);
    @(posedge clk);
    #2;
    check_bit("mid_drain_valid", m_valid, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("async_rst_m_valid", m_valid, 1'b0);
    check_bit("async_rst_s_ready", s_ready, 1'b1);
    check_bit("async_rst_err", err, 1'b0);
    check_blk("async_rst_cph_data", cph_data_o, '0);
    @(negedge clk);
    m_ready = 1'b0;
    rst = 1'b0;

    // Normal block after the mid-drain reset
    send_block(v3, 16, 1'b1);
    wait_req();
    check_blk("post_rst_cph_data", cph_data_o, v3);
    recv_block(v3 ^ KEY, 1'b1, 1'b0, 16);
    check_bit("post_rst_err", err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
